// File: rtl/mv_gen_controller_pkg.sv
// Shared types for the affine MV generator controller: state encoding, walk status codes,
// output bundle decode. Stats widths exist only when MV_GEN_CTRL_STATS_EN is defined.
package mv_gen_controller_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_CLEAR     = 4'd1,
      S_LOAD      = 4'd2,
      S_INIT      = 4'd3,
      S_GEN       = 4'd4,
      S_ISSUE     = 4'd5,
      S_NEXT_COL  = 4'd6,
      S_NEXT_LINE = 4'd7,
      S_FIN       = 4'd8
   } state_t;

   localparam logic [1:0] CTRL_DONE_ALL     = 2'b00;
   localparam logic [1:0] CTRL_NEXT_LINE    = 2'b10;
   localparam logic [1:0] CTRL_NEXT_COL     = 2'b01;
   localparam logic [1:0] CTRL_NEXT_COL_ALT = 2'b11;

`ifdef MV_GEN_CTRL_STATS_EN
   localparam int FRAC_BLOCKS_W  = 5;
   localparam int STALL_CYCLES_W = 16;
`endif

   typedef struct packed {
      logic rst_mv_gen_n;
      logic wr_coords;
      logic wr_cpmvs;
      logic wr_gen_mvs;
      logic wr_x;
      logic wr_y;
      logic wr_count;
      logic sel_x;
      logic sel_y;
      logic mv_valid;
      logic busy;
      logic done;
   } ctrl_out_t;

   localparam ctrl_out_t OUT_IDLE = '{rst_mv_gen_n: 1'b1, default: 1'b0};

   function automatic state_t ctrl_next(input logic [1:0] ctrl);
      state_t nxt;
      case (ctrl)
         CTRL_DONE_ALL:                      nxt = S_FIN;
         CTRL_NEXT_LINE:                     nxt = S_NEXT_LINE;
         CTRL_NEXT_COL, CTRL_NEXT_COL_ALT:   nxt = S_NEXT_COL;
         default:                            nxt = S_NEXT_COL;
      endcase
      return nxt;
   endfunction

   function automatic ctrl_out_t decode_outputs(input state_t st);
      ctrl_out_t o;
      o      = OUT_IDLE;
      o.busy = (st != S_IDLE);
      case (st)
         S_IDLE:      o.busy = 1'b0;
         S_CLEAR:     o.rst_mv_gen_n = 1'b0;
         S_LOAD:      begin o.wr_coords = 1'b1; o.wr_cpmvs = 1'b1; end
         S_INIT:      begin o.wr_x = 1'b1; o.wr_y = 1'b1; end
         S_GEN:       begin o.wr_gen_mvs = 1'b1; o.wr_count = 1'b1; end
         S_ISSUE:     o.mv_valid = 1'b1;
         S_NEXT_COL:  begin o.sel_x = 1'b1; o.wr_x = 1'b1; end
         S_NEXT_LINE: begin o.wr_x = 1'b1; o.sel_y = 1'b1; o.wr_y = 1'b1; end
         S_FIN:       o.done = 1'b1;
         default:     o = OUT_IDLE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mv_gen_ctrl_stats.sv
// Optional handshake statistics for mv_gen_controller; present only with MV_GEN_CTRL_STATS_EN.
`ifdef MV_GEN_CTRL_STATS_EN
module mv_gen_ctrl_stats
   import mv_gen_controller_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      issue,
   input  logic                      ready,
   input  logic [1:0]                interp_mode,
   output logic [FRAC_BLOCKS_W-1:0]  frac_blocks,
   output logic [STALL_CYCLES_W-1:0] stall_cycles
);

   // Saturating counters of fractional handshakes and stalled ISSUE cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frac_blocks  <= {FRAC_BLOCKS_W{1'b0}};
         stall_cycles <= {STALL_CYCLES_W{1'b0}};
      end else if (clear) begin
         frac_blocks  <= {FRAC_BLOCKS_W{1'b0}};
         stall_cycles <= {STALL_CYCLES_W{1'b0}};
      end else begin
         if (issue && ready && (interp_mode != 2'b00) && (frac_blocks != {FRAC_BLOCKS_W{1'b1}}))
            frac_blocks <= frac_blocks + FRAC_BLOCKS_W'(1);
         if (issue && !ready && (stall_cycles != {STALL_CYCLES_W{1'b1}}))
            stall_cycles <= stall_cycles + STALL_CYCLES_W'(1);
      end
   end

endmodule
`endif

// File: rtl/mv_gen_controller.sv
// Sequencer for the affine sub-block MV generator datapath; outputs decoded from the next state
// and registered. Define MV_GEN_CTRL_STATS_EN to add FRAC_BLOCKS / STALL_CYCLES counters.
module mv_gen_controller
   import mv_gen_controller_pkg::*;
(
   input  logic       CLK,
   input  logic       RST_ASYNC,
   input  logic       START,
   input  logic       CTRL_X,
   input  logic       CTRL_Y,
   input  logic       INTERP_X,
   input  logic       INTERP_Y,
   input  logic       MV_READY,
   output logic       RST_ASYNC_MV_GEN,
   output logic       WRITE_REGS_COORDS,
   output logic       WRITE_REGS_CPMVS,
   output logic       WRITE_REGS_GEN_MVS,
   output logic       WRITE_REG_X,
   output logic       WRITE_REG_Y,
   output logic       WRITE_REG_COUNT_BLOCK,
   output logic       SEL_X,
   output logic       SEL_Y,
   output logic       MV_VALID,
   output logic [1:0] INTERP_MODE,
   output logic       BUSY,
   output logic       DONE
`ifdef MV_GEN_CTRL_STATS_EN
   ,
   output logic [FRAC_BLOCKS_W-1:0]  FRAC_BLOCKS,
   output logic [STALL_CYCLES_W-1:0] STALL_CYCLES
`endif
);

   state_t     state_r;
   state_t     next_state_s;
   ctrl_out_t  out_r;
   ctrl_out_t  next_out_s;
   logic [1:0] interp_mode_r;

   // Next state follows the datapath walk status; START only matters in IDLE
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE:      if (START) next_state_s = S_CLEAR; else next_state_s = S_IDLE;
         S_CLEAR:     next_state_s = S_LOAD;
         S_LOAD:      next_state_s = S_INIT;
         S_INIT:      next_state_s = S_GEN;
         S_GEN:       next_state_s = S_ISSUE;
         S_ISSUE:     if (MV_READY) next_state_s = ctrl_next({CTRL_X, CTRL_Y});
                      else          next_state_s = S_ISSUE;
         S_NEXT_COL:  next_state_s = S_GEN;
         S_NEXT_LINE: next_state_s = S_GEN;
         S_FIN:       next_state_s = S_IDLE;
         default:     next_state_s = S_IDLE;
      endcase
      next_out_s = decode_outputs(next_state_s);
   end

   // State and output registers; async reset drops MV_VALID without a DONE
   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         state_r <= S_IDLE;
         out_r   <= OUT_IDLE;
      end else begin
         state_r <= next_state_s;
         out_r   <= next_out_s;
      end
   end

   // Fractional flags are captured alongside the generated MV and held through ISSUE
   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC)
         interp_mode_r <= 2'b00;
      else if (state_r == S_GEN)
         interp_mode_r <= {INTERP_X, INTERP_Y};
      else
         interp_mode_r <= interp_mode_r;
   end

   assign RST_ASYNC_MV_GEN      = out_r.rst_mv_gen_n;
   assign WRITE_REGS_COORDS     = out_r.wr_coords;
   assign WRITE_REGS_CPMVS      = out_r.wr_cpmvs;
   assign WRITE_REGS_GEN_MVS    = out_r.wr_gen_mvs;
   assign WRITE_REG_X           = out_r.wr_x;
   assign WRITE_REG_Y           = out_r.wr_y;
   assign WRITE_REG_COUNT_BLOCK = out_r.wr_count;
   assign SEL_X                 = out_r.sel_x;
   assign SEL_Y                 = out_r.sel_y;
   assign MV_VALID              = out_r.mv_valid;
   assign BUSY                  = out_r.busy;
   assign DONE                  = out_r.done;
   assign INTERP_MODE           = interp_mode_r;

`ifdef MV_GEN_CTRL_STATS_EN
   mv_gen_ctrl_stats u_stats (
      .clk          (CLK),
      .rst          (RST_ASYNC),
      .clear        (state_r == S_CLEAR),
      .issue        (state_r == S_ISSUE),
      .ready        (MV_READY),
      .interp_mode  (interp_mode_r),
      .frac_blocks  (FRAC_BLOCKS),
      .stall_cycles (STALL_CYCLES)
   );
`endif

endmodule

// File: tb/tb_mv_gen_controller.sv
// Directed self-checking bench for mv_gen_controller (stats checks when MV_GEN_CTRL_STATS_EN).
module tb_mv_gen_controller;

   logic       CLK = 1'b0;
   logic       RST_ASYNC, START, CTRL_X, CTRL_Y, INTERP_X, INTERP_Y, MV_READY;
   logic       RST_ASYNC_MV_GEN, WRITE_REGS_COORDS, WRITE_REGS_CPMVS, WRITE_REGS_GEN_MVS;
   logic       WRITE_REG_X, WRITE_REG_Y, WRITE_REG_COUNT_BLOCK, SEL_X, SEL_Y;
   logic       MV_VALID, BUSY, DONE;
   logic [1:0] INTERP_MODE;
`ifdef MV_GEN_CTRL_STATS_EN
   logic [4:0]  FRAC_BLOCKS;
   logic [15:0] STALL_CYCLES;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // {rst_n, coords, cpmvs, gen_mvs, wr_x, wr_y, count, sel_x, sel_y, valid, busy, done}
   localparam logic [11:0] O_IDLE  = 12'h800;
   localparam logic [11:0] O_CLEAR = 12'h002;
   localparam logic [11:0] O_LOAD  = 12'hE02;
   localparam logic [11:0] O_INIT  = 12'h8C2;
   localparam logic [11:0] O_GEN   = 12'h922;
   localparam logic [11:0] O_ISSUE = 12'h806;
   localparam logic [11:0] O_NCOL  = 12'h892;
   localparam logic [11:0] O_NLINE = 12'h8CA;
   localparam logic [11:0] O_FIN   = 12'h803;

   logic [11:0] outs;
   assign outs = {RST_ASYNC_MV_GEN, WRITE_REGS_COORDS, WRITE_REGS_CPMVS, WRITE_REGS_GEN_MVS,
                  WRITE_REG_X, WRITE_REG_Y, WRITE_REG_COUNT_BLOCK, SEL_X, SEL_Y,
                  MV_VALID, BUSY, DONE};

   mv_gen_controller dut (
      .CLK(CLK), .RST_ASYNC(RST_ASYNC), .START(START),
      .CTRL_X(CTRL_X), .CTRL_Y(CTRL_Y), .INTERP_X(INTERP_X), .INTERP_Y(INTERP_Y),
      .MV_READY(MV_READY), .RST_ASYNC_MV_GEN(RST_ASYNC_MV_GEN),
      .WRITE_REGS_COORDS(WRITE_REGS_COORDS), .WRITE_REGS_CPMVS(WRITE_REGS_CPMVS),
      .WRITE_REGS_GEN_MVS(WRITE_REGS_GEN_MVS), .WRITE_REG_X(WRITE_REG_X),
      .WRITE_REG_Y(WRITE_REG_Y), .WRITE_REG_COUNT_BLOCK(WRITE_REG_COUNT_BLOCK),
      .SEL_X(SEL_X), .SEL_Y(SEL_Y), .MV_VALID(MV_VALID), .INTERP_MODE(INTERP_MODE),
      .BUSY(BUSY), .DONE(DONE)
`ifdef MV_GEN_CTRL_STATS_EN
      , .FRAC_BLOCKS(FRAC_BLOCKS), .STALL_CYCLES(STALL_CYCLES)
`endif
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One block walk of cols x rows sub-blocks; negative block indices disable the option
   task automatic walk(input int cols, input int rows, input int stall_blk, input int stall_n,
                       input int frac_blk, input int start_blk, input int abort_blk,
                       input bit hold_start);
      int nblk, hs, lines, last_hs, clear_cyc;
      logic [1:0] code, mode_exp;
      nblk = cols * rows; hs = 0; lines = 0; last_hs = 0;
      START = 1'b1; tick(); START = 1'b0;
      chk("clear", outs, O_CLEAR); clear_cyc = cyc;
      tick(); chk("load", outs, O_LOAD);
      tick(); chk("init", outs, O_INIT);
      tick(); chk("gen0", outs, O_GEN);
      for (int b = 0; b < nblk; b++) begin
         if (b == nblk - 1)            code = 2'b00;
         else if (b % cols == cols - 1) code = 2'b10;
         else                           code = (b % 2 == 1) ? 2'b11 : 2'b01;
         mode_exp = (b == frac_blk) ? 2'b10 : 2'b00;
         {CTRL_X, CTRL_Y}     = code;
         {INTERP_X, INTERP_Y} = mode_exp;
         MV_READY = (b == stall_blk) ? 1'b0 : 1'b1;
         tick();
         chk("issue", outs, O_ISSUE);
         chk("mode", INTERP_MODE, mode_exp);
         // CLEAR is cycle 1 after START, so the first ISSUE sits four edges later
         if (b == 0) chk("first_mv_latency", cyc - clear_cyc, 4);
         {INTERP_X, INTERP_Y} = ~mode_exp;
         if (b == abort_blk) begin
            RST_ASYNC = 1'b1; #1;
            chk("abort_valid", MV_VALID, 1'b0);
            chk("abort_outs", outs, O_IDLE);
            RST_ASYNC = 1'b0;
            repeat (3) begin tick(); chk("abort_no_done", outs, O_IDLE); end
            return;
         end
         if (b == start_blk) START = 1'b1;
         if (b == stall_blk) begin
            repeat (stall_n) begin
               tick();
               chk("stall_outs", outs, O_ISSUE);
               chk("stall_mode", INTERP_MODE, mode_exp);
            end
            MV_READY = 1'b1;
         end
         tick(); START = 1'b0; hs++;
         if (b > 0 && b != stall_blk) chk("issue_rate", cyc - last_hs, 3);
         last_hs = cyc;
         if (code == 2'b00) chk("fin", outs, O_FIN);
         else if (code == 2'b10) begin chk("next_line", outs, O_NLINE); lines++; end
         else chk("next_col", outs, O_NCOL);
         if (code != 2'b00) begin tick(); chk("gen", outs, O_GEN); end
      end
      chk("handshakes", hs, nblk);
      chk("lines", lines, rows - 1);
`ifdef MV_GEN_CTRL_STATS_EN
      chk("stall_cycles", STALL_CYCLES, (stall_blk >= 0) ? stall_n : 0);
      chk("frac_blocks", FRAC_BLOCKS, (frac_blk >= 0) ? 1 : 0);
`endif
      if (hold_start) START = 1'b1;
      tick(); chk("idle_after", outs, O_IDLE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST_ASYNC = 1'b1; START = 1'b0; CTRL_X = 1'b0; CTRL_Y = 1'b0;
      INTERP_X = 1'b0; INTERP_Y = 1'b0; MV_READY = 1'b0;
      repeat (2) tick();
      RST_ASYNC = 1'b0;
      chk("reset_outs", outs, O_IDLE);
      chk("reset_mode", INTERP_MODE, 2'b00);
      tick(); chk("idle_hold", outs, O_IDLE);

      walk(1, 1, -1, 0, -1, -1, -1, 1'b1);   // single sub-block, START held through FIN
      walk(1, 1, -1, 0, -1, -1, -1, 1'b0);   // restart after one idle cycle
      walk(4, 4, -1, 0, -1, 5, -1, 1'b0);    // full 4x4 walk, START ignored in ISSUE
      walk(4, 4, 1, 7, 2, -1, -1, 1'b0);     // stall on sub-block 2, fractional block
      walk(4, 4, -1, 0, -1, -1, 2, 1'b0);    // reset during third ISSUE
      walk(4, 4, -1, 0, -1, -1, -1, 1'b0);   // clean walk after abort
      walk(3, 2, -1, 0, 0, -1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
